// File: rtl/prog_1_1_pkg.sv
// ---------------------------------------------------------------------------
// prog_1_1_pkg
//   Shared constants and types for the 4-input sum-of-products block.
//   IDX_W        : width of the minterm index {a,b,c,d}
//   N_MINTERMS   : number of rows in the truth table (2**IDX_W)
//   DEFAULT_MASK : minterm mask, bit i = F for index i (minterms 0,1,2,5,8,9,10)
//   make_idx()   : packs the four scalar inputs into an index, a is the MSB
// ---------------------------------------------------------------------------
package prog_1_1_pkg;

    localparam int IDX_W      = 4;
    localparam int N_MINTERMS = 1 << IDX_W;

    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [N_MINTERMS-1:0] mask_t;

    // F = b'c' + b'd' + a'c'd
    localparam mask_t DEFAULT_MASK = 16'h0727;

    function automatic idx_t make_idx(input logic a, input logic b,
                                      input logic c, input logic d);
        return {a, b, c, d};
    endfunction

endpackage : prog_1_1_pkg

// File: rtl/prog_1_1_if.sv
// ---------------------------------------------------------------------------
// prog_1_1_if
//   Bundles the function inputs and results of prog_1_1.
//   a,b,c,d : function inputs (a = weight 8 ... d = weight 1)
//   f       : function result (registered or combinational, per instance)
//   f_comb  : combinational function result, zero latency
//   f_valid : f reflects a sampled input vector
//   master  : drives the inputs, observes the results (stimulus side)
//   slave   : the evaluator itself
// ---------------------------------------------------------------------------
interface prog_1_1_if;

    logic a;
    logic b;
    logic c;
    logic d;
    logic f;
    logic f_comb;
    logic f_valid;

    modport master (
        output a, b, c, d,
        input  f, f_comb, f_valid
    );

    modport slave (
        input  a, b, c, d,
        output f, f_comb, f_valid
    );

endinterface : prog_1_1_if

// File: rtl/prog_1_1_sop4_eval.sv
// ---------------------------------------------------------------------------
// sop4_eval
//   Purely combinational 4-input function evaluator: returns mask[idx].
//   idx  : minterm index {a,b,c,d}
//   mask : minterm mask, bit i = function value at index i
//   f    : function value
//   Built as a one-hot minterm decode ANDed with the mask and OR-reduced,
//   which synthesises to the same logic as a 16:1 mux. An X/Z on idx makes
//   the decode compares unknown, so unknowns propagate instead of being
//   silently resolved to a table entry.
// ---------------------------------------------------------------------------
module sop4_eval
    import prog_1_1_pkg::*;
(
    input  idx_t  idx,
    input  mask_t mask,
    output logic  f
);

    logic [N_MINTERMS-1:0] hit;

    generate
        for (genvar gi = 0; gi < N_MINTERMS; gi++) begin : g_minterm
            assign hit[gi] = mask[gi] & (idx == idx_t'(gi));
        end
    endgenerate

    assign f = |hit;

endmodule : sop4_eval

// File: rtl/prog_1_1.sv
// ---------------------------------------------------------------------------
// prog_1_1
//   Programmable 4-input boolean function F(a,b,c,d) = TRUTH_TABLE[{a,b,c,d}].
//   Parameters:
//     TRUTH_TABLE : minterm mask, bit i = F at index i (default 16'h0727)
//     REGISTERED  : 1 = f registered on clk (1-cycle latency),
//                   0 = f follows f_comb and f_valid is tied high
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset, clears f and f_valid
//     bus   : prog_1_1_if.slave (a,b,c,d in; f, f_comb, f_valid out)
//   f_comb is never affected by reset.
// ---------------------------------------------------------------------------
module prog_1_1
    import prog_1_1_pkg::*;
#(
    parameter mask_t TRUTH_TABLE = DEFAULT_MASK,
    parameter bit    REGISTERED  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_1_1_if.slave    bus
);

    idx_t idx;
    logic f_comb;

    assign idx = make_idx(bus.a, bus.b, bus.c, bus.d);

    sop4_eval u_eval (
        .idx  (idx),
        .mask (TRUTH_TABLE),
        .f    (f_comb)
    );

    assign bus.f_comb = f_comb;

    generate
        if (REGISTERED) begin : g_registered
            logic f_reg;
            logic f_valid_reg;

            // f_valid rises on the first edge after reset release and then
            // stays set, since every later edge loads a fresh sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    f_reg       <= 1'b0;
                    f_valid_reg <= 1'b0;
                end else begin
                    f_reg       <= f_comb;
                    f_valid_reg <= 1'b1;
                end
            end

            assign bus.f       = f_reg;
            assign bus.f_valid = f_valid_reg;
        end else begin : g_combinational
            // Clock and reset have no role in this variant.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign bus.f       = f_comb;
            assign bus.f_valid = 1'b1;
        end
    endgenerate

endmodule : prog_1_1

// File: tb/tb_prog_1_1.sv
// ---------------------------------------------------------------------------
// tb_prog_1_1
//   Drives a registered default instance and a combinational 16'h8001
//   instance with the same inputs and checks both against a reference
//   model written from the boolean equations.
// ---------------------------------------------------------------------------
module tb_prog_1_1;

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    prog_1_1_if bus_r ();
    prog_1_1_if bus_c ();

    prog_1_1 u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r.slave)
    );

    prog_1_1 #(
        .TRUTH_TABLE (16'h8001),
        .REGISTERED  (1'b0)
    ) u_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c.slave)
    );

    always #5 clk = ~clk;

    // Reference: F = b'c' + b'd' + a'c'd
    function automatic logic ref_default(input int i);
        logic a, b, c, d;
        a = (i / 8) % 2 == 1;
        b = (i / 4) % 2 == 1;
        c = (i / 2) % 2 == 1;
        d = i % 2 == 1;
        return (!b && !c) || (!b && !d) || (!a && !c && d);
    endfunction

    // Reference for the overridden instance: true only at all-zeros / all-ones
    function automatic logic ref_override(input int i);
        return (i == 0) || (i == 15);
    endfunction

    task automatic check(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic drive(input int i);
        logic [3:0] v;
        v = 4'(i);
        bus_r.a = v[3]; bus_r.b = v[2]; bus_r.c = v[1]; bus_r.d = v[0];
        bus_c.a = v[3]; bus_c.b = v[2]; bus_c.c = v[1]; bus_c.d = v[0];
    endtask

    // Combinational outputs of both instances for the current index
    task automatic check_comb(input string tag, input int i);
        check({tag, "_f_comb"}, bus_r.f_comb, ref_default(i));
        check({tag, "_ovr_f"}, bus_c.f, ref_override(i));
        check({tag, "_ovr_f_comb"}, bus_c.f_comb, ref_override(i));
        check({tag, "_ovr_valid"}, bus_c.f_valid, 1'b1);
    endtask

    // Wait for the next rising edge and settle 1 time unit after it
    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_f;
        int   idx;

        rst_n = 1'b1;
        drive(0);
        edge_settle();
        edge_settle();

        // Reset asserted between edges with idx=0 (f_comb=1)
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_f", bus_r.f, 1'b0);
        check("rst_async_valid", bus_r.f_valid, 1'b0);
        check_comb("rst_async", 0);
        edge_settle();
        check("rst_hold_f", bus_r.f, 1'b0);
        check("rst_hold_valid", bus_r.f_valid, 1'b0);
        #2 rst_n = 1'b1;
        #1;
        check("rst_rel_f", bus_r.f, 1'b0);
        check("rst_rel_valid", bus_r.f_valid, 1'b0);
        edge_settle();
        check("rst_first_f", bus_r.f, 1'b1);
        check("rst_first_valid", bus_r.f_valid, 1'b1);
        exp_f = 1'b1;

        // Exhaustive sweep, each index held for two edges
        for (int i = 0; i < 16; i++) begin
            #2 drive(i);
            #1;
            check_comb($sformatf("sweep%0d", i), i);
            check($sformatf("sweep%0d_hold", i), bus_r.f, exp_f);
            edge_settle();
            exp_f = ref_default(i);
            check($sformatf("sweep%0d_f1", i), bus_r.f, exp_f);
            edge_settle();
            check($sformatf("sweep%0d_f2", i), bus_r.f, exp_f);
            check($sformatf("sweep%0d_valid", i), bus_r.f_valid, 1'b1);
        end

        // Hold: sample idx=3 (f=0), then 0->3->0 between edges
        #2 drive(3);
        edge_settle();
        check("hold_pre_f", bus_r.f, 1'b0);
        #1 drive(0);
        #1 check("hold_glitch_a", bus_r.f_comb, 1'b1);
        check("hold_mid_f_a", bus_r.f, 1'b0);
        #1 drive(3);
        #1 check("hold_glitch_b", bus_r.f_comb, 1'b0);
        check("hold_mid_f_b", bus_r.f, 1'b0);
        #1 drive(0);
        #1 check("hold_glitch_c", bus_r.f_comb, 1'b1);
        check("hold_mid_f_c", bus_r.f, 1'b0);
        edge_settle();
        check("hold_post_f", bus_r.f, 1'b1);

        // Mid-operation reset pulse with idx=9 and f=1
        #2 drive(9);
        edge_settle();
        check("midrst_pre_f", bus_r.f, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_f", bus_r.f, 1'b0);
        check("midrst_valid", bus_r.f_valid, 1'b0);
        check("midrst_f_comb", bus_r.f_comb, 1'b1);
        #1 rst_n = 1'b1;
        #1 check("midrst_rel_f", bus_r.f, 1'b0);
        edge_settle();
        check("midrst_after_f", bus_r.f, 1'b1);
        check("midrst_after_valid", bus_r.f_valid, 1'b1);

        // Randomised: a new index every cycle, registered f trails by one edge
        exp_f = 1'b1;
        for (int n = 0; n < 200; n++) begin
            idx = int'($urandom_range(0, 15));
            #2 drive(idx);
            #1;
            check_comb($sformatf("rand%0d_i%0d", n, idx), idx);
            check($sformatf("rand%0d_hold", n), bus_r.f, exp_f);
            edge_settle();
            exp_f = ref_default(idx);
            check($sformatf("rand%0d_f", n), bus_r.f, exp_f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_prog_1_1
